anita4_l1_trigger_pipe: RTL and testbench

Parametrised N-channel L1 coincidence trigger for the SURF. It registers each antenna-stage trigger input, stretches each rising edge to a programmable width, aligns channels with programmable per-channel delays, and fires a fixed-width L1 one-shot when at least MAJ_CFG unmasked channels overlap. A holdoff state machine rate-limits L1, and an optional saturating scaler counts issued L1s. It generalises the fixed 3-channel, 2-of-3, fixed-stretch TOP/MIDDLE/BOTTOM pipe to arbitrary channel count, majority, stretch width and alignment.

---
 rtl/anita4_l1_trigger_pipe_if.sv | 31 +++
 rtl/anita4_l1_trigger_pipe.sv | 181 ++++++++++++++++++
 tb/tb_anita4_l1_trigger_pipe.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/anita4_l1_trigger_pipe_if.sv
// Bus bundle for the ANITA-4 L1 trigger pipe: trigger inputs, run-time configuration and trigger outputs.
// The master drives triggers and configuration. The slave (the pipe) drives the pulses and the scaler.
interface anita4_l1_trigger_pipe_if #(
    parameter int NCH        = 3,
    parameter int MAXDLY     = 8,
    parameter int WIDTH_BITS = 4
);
    localparam int DW = $clog2(MAXDLY);
    localparam int MW = $clog2(NCH + 1);

    logic [NCH-1:0]            TRIG_IN;
    logic [NCH-1:0]            MASK;
    logic [NCH*DW-1:0]         DELAY_CFG;
    logic [NCH*WIDTH_BITS-1:0] WIDTH_CFG;
    logic [MW-1:0]             MAJ_CFG;
    logic [7:0]                HOLDOFF_CFG;
    logic                      COUNT_CLR;
    logic [NCH-1:0]            TRIGGER_PULSE;
    logic                      L1;
    logic [15:0]               L1_COUNT;

    modport master (
        output TRIG_IN, MASK, DELAY_CFG, WIDTH_CFG, MAJ_CFG, HOLDOFF_CFG, COUNT_CLR,
        input  TRIGGER_PULSE, L1, L1_COUNT
    );

    modport slave (
        input  TRIG_IN, MASK, DELAY_CFG, WIDTH_CFG, MAJ_CFG, HOLDOFF_CFG, COUNT_CLR,
        output TRIGGER_PULSE, L1, L1_COUNT
    );
endinterface

// File: rtl/anita4_l1_trigger_pipe.sv
// N-channel L1 coincidence trigger: edge detect, stretch, per-channel delay, majority, one-shot with holdoff.
// Optional saturating L1 scaler is enabled by defining ANITA_L1_SCALER_EN.
module anita4_l1_trigger_pipe #(
    parameter int NCH        = 3,
    parameter int MAXDLY     = 8,
    parameter int WIDTH_BITS = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    anita4_l1_trigger_pipe_if.slave  bus
);
    localparam int DW = $clog2(MAXDLY);
    localparam int MW = $clog2(NCH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_HOLDOFF} state_t;

    logic [NCH-1:0]                       trig_q, trig_d;
    logic [NCH-1:0]                       trig_hist_q, trig_hist_d;
    logic [NCH-1:0][WIDTH_BITS-1:0]       cnt_q, cnt_d;
    logic [NCH-1:0][MAXDLY-2:0]           dly_q, dly_d;
    logic                                 coinc_q, coinc_d;
    logic                                 coinc_hist_q, coinc_hist_d;
    state_t                               state_q, state_d;
    logic                                 fire_cnt_q, fire_cnt_d;
    logic [7:0]                           hold_q, hold_d;
    logic                                 l1_q, l1_d;

    logic [NCH-1:0]                       rise;
    logic [NCH-1:0]                       stretch;
    logic [NCH-1:0]                       tap;
    logic [MW-1:0]                        pop;
    logic                                 fire;

    assign rise = trig_q & ~trig_hist_q;

    // Stretchers: a rising edge (re)loads the counter; masked channels are held at zero.
    always_comb begin
        trig_d      = bus.TRIG_IN;
        trig_hist_d = trig_q;
        cnt_d       = cnt_q;
        stretch     = '0;
        for (int i = 0; i < NCH; i++) begin
            stretch[i] = (cnt_q[i] != '0);
            if (bus.MASK[i]) begin
                cnt_d[i] = '0;
            end else if (rise[i]) begin
                cnt_d[i] = (bus.WIDTH_CFG[i*WIDTH_BITS +: WIDTH_BITS] == '0) ?
                           WIDTH_BITS'(1) : bus.WIDTH_CFG[i*WIDTH_BITS +: WIDTH_BITS];
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - WIDTH_BITS'(1);
            end
        end
    end

    // Alignment delay lines; a tap select of 0 bypasses the line entirely.
    always_comb begin
        dly_d = dly_q;
        tap   = '0;
        for (int i = 0; i < NCH; i++) begin
            dly_d[i][0] = stretch[i];
            for (int k = 1; k < MAXDLY - 1; k++) begin
                dly_d[i][k] = dly_q[i][k-1];
            end
            tap[i] = stretch[i];
            for (int k = 1; k < MAXDLY; k++) begin
                if (bus.DELAY_CFG[i*DW +: DW] == DW'(k)) begin
                    tap[i] = dly_q[i][k-1];
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NCH; i++) begin
            pop = pop + MW'(tap[i]);
        end
        coinc_d      = (pop >= bus.MAJ_CFG) && (bus.MAJ_CFG != '0);
        coinc_hist_d = coinc_q;
    end

    // Only a fresh coincidence edge seen while idle can start a one-shot.
    assign fire = (state_q == ST_IDLE) && coinc_q && !coinc_hist_q;

    always_comb begin
        state_d    = state_q;
        fire_cnt_d = fire_cnt_q;
        hold_d     = hold_q;
        l1_d       = l1_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    state_d    = ST_FIRE;
                    fire_cnt_d = 1'b0;
                    l1_d       = 1'b1;
                end
            end
            ST_FIRE: begin
                if (!fire_cnt_q) begin
                    fire_cnt_d = 1'b1;
                end else begin
                    l1_d = 1'b0;
                    if (bus.HOLDOFF_CFG == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hold_d  = bus.HOLDOFF_CFG - 8'd1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                l1_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            trig_q       <= '0;
            trig_hist_q  <= '0;
            cnt_q        <= '0;
            dly_q        <= '0;
            coinc_q      <= 1'b0;
            coinc_hist_q <= 1'b0;
            state_q      <= ST_IDLE;
            fire_cnt_q   <= 1'b0;
            hold_q       <= 8'd0;
            l1_q         <= 1'b0;
        end else begin
            trig_q       <= trig_d;
            trig_hist_q  <= trig_hist_d;
            cnt_q        <= cnt_d;
            dly_q        <= dly_d;
            coinc_q      <= coinc_d;
            coinc_hist_q <= coinc_hist_d;
            state_q      <= state_d;
            fire_cnt_q   <= fire_cnt_d;
            hold_q       <= hold_d;
            l1_q         <= l1_d;
        end
    end

    assign bus.TRIGGER_PULSE = stretch;
    assign bus.L1            = l1_q;

`ifdef ANITA_L1_SCALER_EN
    logic [15:0] l1_count_q, l1_count_d;

    // A clear coinciding with a fire keeps that fire in the count.
    always_comb begin
        l1_count_d = l1_count_q;
        if (bus.COUNT_CLR) begin
            l1_count_d = fire ? 16'd1 : 16'd0;
        end else if (fire && (l1_count_q != 16'hFFFF)) begin
            l1_count_d = l1_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            l1_count_q <= 16'd0;
        end else begin
            l1_count_q <= l1_count_d;
        end
    end

    assign bus.L1_COUNT = l1_count_q;
`else
    logic unused_count_clr;
    assign unused_count_clr = bus.COUNT_CLR;
    assign bus.L1_COUNT     = 16'd0;
`endif
endmodule

// File: tb/tb_anita4_l1_trigger_pipe.sv
// Directed bench for anita4_l1_trigger_pipe with hand-computed pulse/L1 histories (bit k = value after edge k).
module tb_anita4_l1_trigger_pipe;
    localparam int NCH        = 3;
    localparam int MAXDLY     = 8;
    localparam int WIDTH_BITS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    anita4_l1_trigger_pipe_if #(.NCH(NCH), .MAXDLY(MAXDLY), .WIDTH_BITS(WIDTH_BITS)) bus ();

    anita4_l1_trigger_pipe #(.NCH(NCH), .MAXDLY(MAXDLY), .WIDTH_BITS(WIDTH_BITS)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    logic [31:0] l1h, tp0h, tp1h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef ANITA_L1_SCALER_EN
        return 32'(n);
`else
        return (n == n) ? 32'd0 : 32'd1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.TRIG_IN   = '0;
        bus.COUNT_CLR = 1'b0;
        repeat (n) tick();
    endtask

    task automatic cfg(input logic [2:0] mask, input logic [1:0] maj, input logic [11:0] w,
                       input logic [8:0] d, input logic [7:0] h);
        bus.MASK        = mask;
        bus.MAJ_CFG     = maj;
        bus.WIDTH_CFG   = w;
        bus.DELAY_CFG   = d;
        bus.HOLDOFF_CFG = h;
    endtask

    // Each channel is high for one cycle before edge t (-1 = never); ch0 may pulse twice.
    task automatic seq(input int t0, input int t0b, input int t1, input int t2, input int clr_at,
                       output logic [31:0] l1o, output logic [31:0] p0o, output logic [31:0] p1o);
        idle(20);
        l1o = '0; p0o = '0; p1o = '0;
        for (int k = 0; k < 24; k++) begin
            bus.TRIG_IN[0] = (k == t0) || (k == t0b);
            bus.TRIG_IN[1] = (k == t1);
            bus.TRIG_IN[2] = (k == t2);
            bus.COUNT_CLR  = (k == clr_at);
            tick();
            l1o[k] = bus.L1;
            p0o[k] = bus.TRIGGER_PULSE[0];
            p1o[k] = bus.TRIGGER_PULSE[1];
        end
        bus.TRIG_IN   = '0;
        bus.COUNT_CLR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        bus.TRIG_IN   = '0;
        bus.COUNT_CLR = 1'b0;
        cfg(3'b000, 2'd2, 12'h444, 9'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_l1", 32'(bus.L1), 32'd0);
        chk("reset_pulse", 32'(bus.TRIGGER_PULSE), 32'd0);
        chk("reset_count", 32'(bus.L1_COUNT), 32'd0);
        rst_n = 1'b1;

        // Basic 2-of-3 overlap: ch0 at 0, ch1 at 2, width 4.
        seq(0, -1, 2, -1, -1, l1h, tp0h, tp1h);
        exp_cnt = 1;
        chk("t1_l1", l1h, 32'h60);
        chk("t1_tp0", tp0h, 32'h1E);
        chk("t1_tp1", tp1h, 32'h78);
        chk("t1_count", 32'(bus.L1_COUNT), cnt_exp(exp_cnt));

        seq(0, -1, 5, -1, -1, l1h, tp0h, tp1h);
        chk("t2_no_overlap", l1h, 32'h0);
        cfg(3'b000, 2'd2, 12'h444, 9'b000_000_011, 8'd0);
        seq(0, -1, 5, -1, -1, l1h, tp0h, tp1h);
        exp_cnt = 2;
        chk("t2_delayed", l1h, 32'h300);
        chk("t2_count", 32'(bus.L1_COUNT), cnt_exp(exp_cnt));

        cfg(3'b010, 2'd2, 12'h444, 9'd0, 8'd0);
        seq(0, -1, 0, -1, -1, l1h, tp0h, tp1h);
        chk("t3_mask_l1", l1h, 32'h0);
        chk("t3_mask_tp1", tp1h, 32'h0);
        chk("t3_mask_tp0", tp0h, 32'h1E);
        cfg(3'b010, 2'd1, 12'h444, 9'd0, 8'd0);
        seq(0, -1, 0, -1, -1, l1h, tp0h, tp1h);
        exp_cnt = 3;
        chk("t3_maj1", l1h, 32'h18);
        cfg(3'b000, 2'd0, 12'h444, 9'd0, 8'd0);
        seq(0, -1, 0, 0, -1, l1h, tp0h, tp1h);
        chk("t3_maj0", l1h, 32'h0);
        cfg(3'b000, 2'd3, 12'h444, 9'd0, 8'd0);
        seq(0, -1, 0, 0, -1, l1h, tp0h, tp1h);
        exp_cnt = 4;
        chk("t3_maj3", l1h, 32'h18);
        chk("t3_count", 32'(bus.L1_COUNT), cnt_exp(exp_cnt));

        // Holdoff of 10: second coincidence 6 cycles later is dropped, 14 later fires.
        cfg(3'b000, 2'd1, 12'h444, 9'd0, 8'd10);
        seq(0, 6, -1, -1, -1, l1h, tp0h, tp1h);
        exp_cnt = 5;
        chk("t4_hold_6", l1h, 32'h18);
        seq(0, 14, -1, -1, -1, l1h, tp0h, tp1h);
        exp_cnt = 7;
        chk("t4_hold_14", l1h, 32'h00060018);
        chk("t4_count", 32'(bus.L1_COUNT), cnt_exp(exp_cnt));

        cfg(3'b000, 2'd0, 12'h440, 9'd0, 8'd0);
        seq(0, -1, -1, -1, -1, l1h, tp0h, tp1h);
        chk("t5_width0", tp0h, 32'h2);
        cfg(3'b000, 2'd0, 12'h444, 9'd0, 8'd0);
        seq(0, 2, -1, -1, -1, l1h, tp0h, tp1h);
        chk("t5_retrig", tp0h, 32'h7E);

        cfg(3'b000, 2'd2, 12'h444, 9'd0, 8'd0);
        seq(-1, -1, -1, -1, 0, l1h, tp0h, tp1h);
        exp_cnt = 0;
        chk("t6_clr", 32'(bus.L1_COUNT), cnt_exp(exp_cnt));
        seq(0, -1, 2, -1, 5, l1h, tp0h, tp1h);
        exp_cnt = 1;
        chk("t6_clr_fire_l1", l1h, 32'h60);
        chk("t6_clr_fire", 32'(bus.L1_COUNT), cnt_exp(exp_cnt));
`ifdef ANITA_L1_SCALER_EN
        force dut.l1_count_d = 16'hFFFE;
        tick();
        release dut.l1_count_d;
        #1;
        chk("t6_preload", 32'(bus.L1_COUNT), 32'hFFFE);
        seq(0, -1, 2, -1, -1, l1h, tp0h, tp1h);
        chk("t6_sat1", 32'(bus.L1_COUNT), 32'hFFFF);
        seq(0, -1, 2, -1, -1, l1h, tp0h, tp1h);
        chk("t6_sat2", 32'(bus.L1_COUNT), 32'hFFFF);
        chk("t6_sat2_l1", l1h, 32'h60);
`endif

        // Asynchronous reset in the middle of FIRE, then release with ch0 held high.
        idle(20);
        for (int k = 0; k < 6; k++) begin
            bus.TRIG_IN[0] = (k == 0);
            bus.TRIG_IN[1] = (k == 2);
            tick();
        end
        chk("t7_pre_l1", 32'(bus.L1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_l1", 32'(bus.L1), 32'd0);
        chk("t7_rst_pulse", 32'(bus.TRIGGER_PULSE), 32'd0);
        chk("t7_rst_count", 32'(bus.L1_COUNT), 32'd0);
        bus.TRIG_IN = 3'b001;
        tick();
        tick();
        chk("t7_held_pulse", 32'(bus.TRIGGER_PULSE), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t7_rel_a0", 32'(bus.TRIGGER_PULSE), 32'd0);
        tick();
        chk("t7_rel_a1", 32'(bus.TRIGGER_PULSE), 32'd1);
        tick();
        tick();
        tick();
        chk("t7_rel_a4", 32'(bus.TRIGGER_PULSE), 32'd1);
        tick();
        chk("t7_rel_a5", 32'(bus.TRIGGER_PULSE), 32'd0);
        bus.TRIG_IN = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
